// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: word width, NOP encoding
// and the {instr, pc} packet handed to decode.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; payload type is a parameter so the same
// block serves the instruction queue and the in-flight PC queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type T = fetch_pkt_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  T                         data_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so push+pop on a full queue is legal.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : fetch_fifo

// File: rtl/s1_fetch_stage.sv
// Fetch stage: owns the PC, issues credit-limited word reads to instruction
// memory, queues returned words and squashes stale responses after a redirect.
module s1_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   kill_q, kill_d;

  logic            grant, accept, q_pop, q_empty;
  logic [CW-1:0]   q_count;
  fetch_pkt_t      q_wdata, q_head;
  logic [XLEN-1:0] if_head;

  logic            q_full_unused, if_full_unused, if_empty_unused;
  logic [CW-1:0]   if_count_unused;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_pkt_t)) u_instr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (q_pop),
    .flush_i (redirect_i),
    .data_i  (q_wdata),
    .data_o  (q_head),
    .full_o  (q_full_unused),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // PCs of granted-but-unanswered requests; only live (unkilled) ones remain after a flush.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) u_inflight_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .pop_i   (accept),
    .flush_i (redirect_i),
    .data_i  (pc_q),
    .data_o  (if_head),
    .full_o  (if_full_unused),
    .empty_o (if_empty_unused),
    .count_o (if_count_unused)
  );

  assign imem_addr_o = pc_q;

  always_comb begin
    imem_req_o    = 1'b0;
    grant         = 1'b0;
    accept        = 1'b0;
    dec_valid_o   = 1'b0;
    q_pop         = 1'b0;
    dec_instr_o   = '0;
    dec_pc_o      = '0;
    q_wdata       = '0;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;

    imem_req_o = rst_n && !redirect_i
                 && ((SW'(q_count) + SW'(outstanding_q)) < SW'(FIFO_DEPTH))
                 && (outstanding_q != CW'(FIFO_DEPTH));
    grant  = imem_req_o && imem_gnt_i;
    accept = imem_rvalid_i && (kill_q == '0) && !redirect_i;

    dec_valid_o = !q_empty && !redirect_i;
    q_pop       = dec_valid_o && dec_ready_i;
    q_wdata     = '{instr: imem_rdata_i, pc: if_head};

    if (!rst_n) begin
      dec_instr_o = '0;
    end else if (q_empty) begin
      dec_instr_o = INSTR_NOP;
    end else begin
      dec_instr_o = q_head.instr;
    end
    dec_pc_o = q_empty ? '0 : q_head.pc;

    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);

    // Every response still owed after a redirect belongs to the old stream.
    if (redirect_i) begin
      pc_d   = redirect_pc_i & ~XLEN'(3);
      kill_d = outstanding_q - CW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (imem_rvalid_i && (kill_q != '0)) begin
        kill_d = kill_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

endmodule : s1_fetch_stage

// File: tb/tb_s1_fetch_stage.sv
// Directed bench for s1_fetch_stage with a one-cycle-latency memory model and
// a collector recording every instruction accepted by decode.
module tb_s1_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;

  int          checks = 0;
  int          errors = 0;
  logic        resp_en;
  int          grant_cnt;
  logic [31:0] pend[$];
  logic [31:0] seen_pc[$];
  logic [31:0] seen_instr[$];

  s1_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_instr_o   (dec_instr_o),
    .dec_pc_o      (dec_pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory: record grants before the edge, answer in order one cycle later.
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_o && imem_gnt_i) begin
        pend.push_back(imem_addr_o);
        grant_cnt++;
      end
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end else if (resp_en && pend.size() > 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = imem_word(pend.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dec_valid_o && dec_ready_i) begin
        seen_pc.push_back(dec_pc_o);
        seen_instr.push_back(dec_instr_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    seen_pc.delete();
    seen_instr.delete();
    grant_cnt = 0;
  endtask

  task automatic do_reset();
    tick();
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    resp_en       = 1'b0;
    dec_ready_i   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; resp_en = 1'b0; dec_ready_i = 1'b0;
    grant_cnt = 0;
    tick(); tick();
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr_o); end
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dec_valid_o); end
    checks++; if (dec_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", dec_instr_o); end
    checks++; if (dec_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", dec_pc_o); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_req_o); end
    checks++; if (dec_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL empty_nop got %h want 00000013", dec_instr_o); end
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", dec_valid_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    dec_ready_i = 1'b1; imem_gnt_i = 1'b1; resp_en = 1'b1;
    repeat (24) tick();
    for (int i = 0; i < 6; i++) begin
      exp = 32'(i * 4);
      checks++;
      if (i >= seen_pc.size()) begin errors++; $display("FAIL stream_missing[%0d] got none want pc %h", i, exp); end
      else if (seen_pc[i] !== exp || seen_instr[i] !== imem_word(exp)) begin
        errors++; $display("FAIL stream[%0d] got pc %h instr %h want pc %h instr %h", i, seen_pc[i], seen_instr[i], exp, imem_word(exp));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    do_reset();
    dec_ready_i = 1'b0; imem_gnt_i = 1'b1; resp_en = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    checks++; if (grant_cnt !== 2) begin errors++; $display("FAIL stall_grants got %0d want 2", grant_cnt); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", imem_req_o); end
    checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", dec_valid_o); end
    checks++; if (dec_pc_o !== 32'h0) begin errors++; $display("FAIL stall_head_pc got %h want 0", dec_pc_o); end
    checks++; if (dec_instr_o !== imem_word(32'h0)) begin errors++; $display("FAIL stall_head_instr got %h want %h", dec_instr_o, imem_word(32'h0)); end
    tick();
    dec_ready_i = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 3; i++) begin
      exp = 32'(i * 4);
      checks++;
      if (i >= seen_pc.size()) begin errors++; $display("FAIL drain_missing[%0d] got none want pc %h", i, exp); end
      else if (seen_pc[i] !== exp || seen_instr[i] !== imem_word(exp)) begin
        errors++; $display("FAIL drain[%0d] got pc %h instr %h want pc %h instr %h", i, seen_pc[i], seen_instr[i], exp, imem_word(exp));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    do_reset();
    dec_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h10;
    tick();
    redirect_i = 1'b0; imem_gnt_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (grant_cnt !== 2) begin errors++; $display("FAIL redir_outstanding got %0d grants want 2", grant_cnt); end
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0 || dec_valid_o !== 1'b0) begin errors++; $display("FAIL redir_cycle got req %b valid %b want 0 0", imem_req_o, dec_valid_o); end
    tick();
    redirect_i = 1'b0; resp_en = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL redir_addr got %h want 00000200", imem_addr_o); end
    repeat (14) tick();
    for (int i = 0; i < 2; i++) begin
      exp = 32'h200 + 32'(i * 4);
      checks++;
      if (i >= seen_pc.size()) begin errors++; $display("FAIL redir_missing[%0d] got none want pc %h", i, exp); end
      else if (seen_pc[i] !== exp || seen_instr[i] !== imem_word(exp)) begin
        errors++; $display("FAIL redir[%0d] got pc %h instr %h want pc %h instr %h", i, seen_pc[i], seen_instr[i], exp, imem_word(exp));
      end
    end
  endtask

  task automatic test_redirect_rvalid();
    logic [31:0] exp;
    do_reset();
    dec_ready_i = 1'b1; imem_gnt_i = 1'b1;
    tick(); tick();
    imem_gnt_i = 1'b0;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100; resp_en = 1'b1;
    @(negedge clk);
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rr_cycle_valid got %b want 0", dec_valid_o); end
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h300; resp_en = 1'b0;
    tick();
    redirect_i = 1'b0; imem_gnt_i = 1'b1; resp_en = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr_o !== 32'h300) begin errors++; $display("FAIL rr_addr got %h want 00000300", imem_addr_o); end
    repeat (14) tick();
    for (int i = 0; i < 3; i++) begin
      exp = 32'h300 + 32'(i * 4);
      checks++;
      if (i >= seen_pc.size()) begin errors++; $display("FAIL rr_missing[%0d] got none want pc %h", i, exp); end
      else if (seen_pc[i] !== exp || seen_instr[i] !== imem_word(exp)) begin
        errors++; $display("FAIL rr[%0d] got pc %h instr %h want pc %h instr %h", i, seen_pc[i], seen_instr[i], exp, imem_word(exp));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    do_reset();
    dec_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0; imem_gnt_i = 1'b1; resp_en = 1'b1;
    repeat (14) tick();
    for (int i = 0; i < 3; i++) begin
      exp = 32'hFFFF_FFFC + 32'(i * 4);
      checks++;
      if (i >= seen_pc.size()) begin errors++; $display("FAIL wrap_missing[%0d] got none want pc %h", i, exp); end
      else if (seen_pc[i] !== exp || seen_instr[i] !== imem_word(exp)) begin
        errors++; $display("FAIL wrap[%0d] got pc %h instr %h want pc %h instr %h", i, seen_pc[i], seen_instr[i], exp, imem_word(exp));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp;
    do_reset();
    dec_ready_i = 1'b0; imem_gnt_i = 1'b1; resp_en = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    checks++; if (dec_valid_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL pre_areset got valid %b addr %h want 1 00000008", dec_valid_o, imem_addr_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", dec_valid_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL areset_addr got %h want 0", imem_addr_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL areset_req got %b want 0", imem_req_o); end
    tick(); tick();
    rst_n = 1'b1; dec_ready_i = 1'b1;
    clear_logs();
    repeat (12) tick();
    for (int i = 0; i < 2; i++) begin
      exp = 32'(i * 4);
      checks++;
      if (i >= seen_pc.size()) begin errors++; $display("FAIL restart_missing[%0d] got none want pc %h", i, exp); end
      else if (seen_pc[i] !== exp || seen_instr[i] !== imem_word(exp)) begin
        errors++; $display("FAIL restart[%0d] got pc %h instr %h want pc %h instr %h", i, seen_pc[i], seen_instr[i], exp, imem_word(exp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_s1_fetch_stage
